// File: rtl/fft_pkg.sv
// Shared fixed-point helpers for the FFT datapath: part width, rounding,
// saturation and packing of complex {re, im} words.
package fft_pkg;

    localparam int unsigned MAX_W = 64;

    typedef logic signed [MAX_W-1:0] wide_t;

    // ovf sits above val so a plain truncation of a sat_t yields the value bits
    typedef struct packed {
        logic  ovf;
        wide_t val;
    } sat_t;

    function automatic int unsigned part_w(input int unsigned w);
        return w / 2;
    endfunction

    function automatic wide_t round_const(input int unsigned n);
        return (n == 0) ? '0 : (wide_t'(1) <<< (n - 1));
    endfunction

    function automatic sat_t sat_d(input wide_t v, input int unsigned d);
        sat_t  r;
        wide_t hi;
        wide_t lo;
        hi    = (wide_t'(1) <<< (d - 1)) - wide_t'(1);
        lo    = -(wide_t'(1) <<< (d - 1));
        r.ovf = 1'b0;
        r.val = v;
        if (v > hi) begin
            r.val = hi;
            r.ovf = 1'b1;
        end else if (v < lo) begin
            r.val = lo;
            r.ovf = 1'b1;
        end
        return r;
    endfunction

    function automatic wide_t unpack_re(input logic [MAX_W-1:0] w, input int unsigned d);
        wide_t t;
        t = wide_t'(w << (MAX_W - 2 * d));
        return t >>> (MAX_W - d);
    endfunction

    function automatic wide_t unpack_im(input logic [MAX_W-1:0] w, input int unsigned d);
        wide_t t;
        t = wide_t'(w << (MAX_W - d));
        return t >>> (MAX_W - d);
    endfunction

    function automatic logic [MAX_W-1:0] pack(input wide_t re, input wide_t im, input int unsigned d);
        logic [MAX_W-1:0] mask;
        mask = (MAX_W'(1) << d) - MAX_W'(1);
        return ((re & mask) << d) | (im & mask);
    endfunction

endpackage

// File: rtl/cmul_round.sv
// Butterfly stage 2: full-precision complex product B*T, rounded half-up
// by N fractional bits and registered while enabled.
module cmul_round
    import fft_pkg::*;
#(
    parameter int unsigned W = 16,
    parameter int unsigned N = 4
) (
    input  logic                clk,
    input  logic                en_i,
    input  logic [W-1:0]        b_i,
    input  logic [W-1:0]        t_i,
    output logic signed [W:0]   pr_o,
    output logic signed [W:0]   pi_o
);

    localparam int unsigned D  = part_w(W);
    localparam int unsigned PW = 2 * D + 1;

    logic signed [D-1:0]  b_re, b_im, t_re, t_im;
    logic signed [PW-1:0] pr_c, pi_c;
    logic signed [PW-1:0] pr_d, pi_d;
    logic signed [PW-1:0] pr_q, pi_q;

    always_comb begin
        b_re = D'(unpack_re(MAX_W'(b_i), D));
        b_im = D'(unpack_im(MAX_W'(b_i), D));
        t_re = D'(unpack_re(MAX_W'(t_i), D));
        t_im = D'(unpack_im(MAX_W'(t_i), D));
        pr_c = PW'(b_re) * PW'(t_re) - PW'(b_im) * PW'(t_im);
        pi_c = PW'(b_re) * PW'(t_im) + PW'(b_im) * PW'(t_re);
        pr_d = (pr_c + PW'(round_const(N))) >>> N;
        pi_d = (pi_c + PW'(round_const(N))) >>> N;
    end

    always_ff @(posedge clk) begin
        if (en_i) begin
            pr_q <= pr_d;
            pi_q <= pi_d;
        end
    end

    assign pr_o = pr_q;
    assign pi_o = pi_q;

endmodule

// File: rtl/butterfly_2_pipe.sv
// Three-stage radix-2 DIT butterfly X = A + B*T, Y = A - B*T with optional
// conjugate twiddle, /2 scaling, saturation, sticky overflow and valid/ready.
module butterfly_2_pipe
    import fft_pkg::*;
#(
    parameter int unsigned W = 16,
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_1,
    input  logic [W-1:0] in_2,
    input  logic [W-1:0] tw,
    input  logic         inverse,
    input  logic         scale,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_x,
    output logic [W-1:0] out_y,
    output logic         ovf,
    input  logic         clr_ovf
);

    localparam int unsigned D  = part_w(W);
    localparam int unsigned PW = 2 * D + 1;
    localparam int unsigned SW = PW + 1;
    localparam logic signed [D-1:0] PART_MIN = {1'b1, {(D-1){1'b0}}};
    localparam logic signed [D-1:0] PART_MAX = {1'b0, {(D-1){1'b1}}};

    logic                 en;
    logic signed [D-1:0]  tw_im_c, tw_im_conj_c;
    logic [W-1:0]         s1_t_d;
    logic [W-1:0]         s1_a_q, s1_b_q, s1_t_q;
    logic                 s1_scale_q, s1_valid_q;
    logic [W-1:0]         s2_a_q;
    logic                 s2_scale_q, s2_valid_q;
    logic signed [PW-1:0] s2_pr, s2_pi;
    logic signed [D-1:0]  a_re, a_im;
    logic signed [SW-1:0] raw_c [4];
    logic signed [SW-1:0] sum_c [4];
    logic [D-1:0]         res_c [4];
    logic [3:0]           part_ovf_c;
    logic [W-1:0]         x_d, y_d, x_q, y_q;
    logic                 valid_q, ovf_d, ovf_q;

    // Whole pipeline freezes while the output word is held by the sink
    assign en       = ~(valid_q & ~out_ready);
    assign in_ready = en;

    // Conjugate twiddle; negating the most negative part saturates
    always_comb begin
        tw_im_c      = signed'(tw[D-1:0]);
        tw_im_conj_c = (tw_im_c == PART_MIN) ? PART_MAX : -tw_im_c;
        s1_t_d       = inverse ? {tw[W-1:D], tw_im_conj_c} : tw;
    end

    cmul_round #(
        .W (W),
        .N (N)
    ) u_cmul (
        .clk  (clk),
        .en_i (en),
        .b_i  (s1_b_q),
        .t_i  (s1_t_q),
        .pr_o (s2_pr),
        .pi_o (s2_pi)
    );

    // Stage 3: sum/difference, optional floor halving, saturate each part
    always_comb begin
        a_re     = signed'(s2_a_q[W-1:D]);
        a_im     = signed'(s2_a_q[D-1:0]);
        raw_c[0] = SW'(a_re) + SW'(s2_pr);
        raw_c[1] = SW'(a_im) + SW'(s2_pi);
        raw_c[2] = SW'(a_re) - SW'(s2_pr);
        raw_c[3] = SW'(a_im) - SW'(s2_pi);
        for (int i = 0; i < 4; i++) begin
            sum_c[i]      = s2_scale_q ? (raw_c[i] >>> 1) : raw_c[i];
            res_c[i]      = D'(sat_d(MAX_W'(sum_c[i]), D));
            part_ovf_c[i] = 1'(sat_d(MAX_W'(sum_c[i]), D) >> MAX_W);
        end
        x_d = W'(pack(MAX_W'(res_c[0]), MAX_W'(res_c[1]), D));
        y_d = W'(pack(MAX_W'(res_c[2]), MAX_W'(res_c[3]), D));
    end

    // Set beats clear when both land on the same edge
    always_comb begin
        ovf_d = ovf_q;
        if (en && s2_valid_q && (|part_ovf_c)) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            valid_q    <= 1'b0;
            x_q        <= '0;
            y_q        <= '0;
            ovf_q      <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            if (en) begin
                s1_valid_q <= in_valid;
                s2_valid_q <= s1_valid_q;
                valid_q    <= s2_valid_q;
                x_q        <= x_d;
                y_q        <= y_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            s1_a_q     <= in_1;
            s1_b_q     <= in_2;
            s1_t_q     <= s1_t_d;
            s1_scale_q <= scale;
            s2_a_q     <= s1_a_q;
            s2_scale_q <= s1_scale_q;
        end
    end

    assign out_valid = valid_q;
    assign out_x     = x_q;
    assign out_y     = y_q;
    assign ovf       = ovf_q;

endmodule
